// File: rtl/sprite_eval_if.sv
// sprite_eval_if: control, primary OAM read port and secondary OAM write port of sprite_eval
interface sprite_eval_if #(
  parameter int NUM_SPRITES  = 64,
  parameter int MAX_PER_LINE = 8,
  parameter int Y_W          = 8
);
  logic                              start;
  logic                              abort;
  logic [Y_W-1:0]                    scanline;
  logic                              tall;
  logic [$clog2(NUM_SPRITES*4)-1:0]  oam_addr;
  logic [7:0]                        oam_rdata;
  logic                              sec_we;
  logic [$clog2(MAX_PER_LINE*4)-1:0] sec_addr;
  logic [7:0]                        sec_wdata;
  logic                              busy;
  logic                              done;
  logic [$clog2(MAX_PER_LINE+1)-1:0] count;
  logic                              overflow;
  logic                              sprite0_hit;
  modport master (
    output start, abort, scanline, tall, oam_rdata,
    input  oam_addr, sec_we, sec_addr, sec_wdata, busy, done, count, overflow, sprite0_hit
  );
  modport slave (
    input  start, abort, scanline, tall, oam_rdata,
    output oam_addr, sec_we, sec_addr, sec_wdata, busy, done, count, overflow, sprite0_hit
  );
endinterface

// File: rtl/sprite_eval.sv
// sprite_eval: per-scanline sprite evaluator, clears secondary OAM then copies sprites hitting the line
module sprite_eval #(
  parameter int NUM_SPRITES  = 64,
  parameter int MAX_PER_LINE = 8,
  parameter int Y_W          = 8
) (
  input logic          clk,
  input logic          reset_n,
  sprite_eval_if.slave bus
);
  localparam int IW = $clog2(NUM_SPRITES);
  localparam int OW = $clog2(NUM_SPRITES*4);
  localparam int SW = $clog2(MAX_PER_LINE*4);
  localparam int CW = $clog2(MAX_PER_LINE+1);
  typedef enum logic [2:0] {IDLE, CLEAR, SCAN, CHECK, COPY1, COPY2, COPY3, DONE} state_t;
  state_t         state;
  logic [1:0]     rst_sync;
  logic           rst_n;
  logic [Y_W-1:0] line;
  logic           tall;
  logic [IW-1:0]  idx;
  logic [SW-1:0]  clr;
  logic [OW-1:0]  addr_q;
  logic [CW-1:0]  count;
  logic           overflow;
  logic           sprite0_hit;
  logic [Y_W:0]   diff;
  logic           hit;
  logic           room;
  logic           last;
  logic           wr_hit;
  logic           we;
  logic [1:0]     ph;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  // Write/read strobes depend on the OAM byte arriving this cycle, so they are decoded, not registered
  always_comb begin
    diff   = {1'b0, line} - {1'b0, Y_W'(bus.oam_rdata)};
    hit    = !diff[Y_W] && diff < (tall ? (Y_W+1)'(16) : (Y_W+1)'(8));
    room   = count < CW'(MAX_PER_LINE);
    last   = idx == IW'(NUM_SPRITES-1);
    wr_hit = state == CHECK && hit && room;
    ph     = state == COPY1 ? 2'd1 : state == COPY2 ? 2'd2 : state == COPY3 ? 2'd3 : 2'd0;
    we     = !bus.abort && (state == CLEAR || wr_hit || state inside {COPY1, COPY2, COPY3});
    bus.sec_we    = we;
    bus.sec_addr  = !we ? '0 : state == CLEAR ? clr : SW'({count, ph});
    bus.sec_wdata = !we ? '0 : state == CLEAR ? 8'hFF : bus.oam_rdata;
    bus.oam_addr  = state == SCAN ? {idx, 2'd0} :
                    wr_hit || state inside {COPY1, COPY2} ? {idx, ph + 2'd1} : addr_q;
  end
  assign bus.busy        = state inside {CLEAR, SCAN, CHECK, COPY1, COPY2, COPY3};
  assign bus.done        = state == DONE;
  assign bus.count       = count;
  assign bus.overflow    = overflow;
  assign bus.sprite0_hit = sprite0_hit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      line        <= '0;
      tall        <= 1'b0;
      idx         <= '0;
      clr         <= '0;
      addr_q      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      sprite0_hit <= 1'b0;
    end else begin
      addr_q <= bus.oam_addr;
      if (bus.abort) state <= IDLE;
      else case (state)
        IDLE: if (bus.start) begin
          line        <= bus.scanline;
          tall        <= bus.tall;
          count       <= '0;
          overflow    <= 1'b0;
          sprite0_hit <= 1'b0;
          idx         <= '0;
          clr         <= '0;
          state       <= CLEAR;
        end
        CLEAR: begin
          clr <= clr + 1'b1;
          if (clr == SW'(MAX_PER_LINE*4-1)) state <= SCAN;
        end
        SCAN: state <= CHECK;
        CHECK: begin
          if (!hit && !last) idx <= idx + 1'b1;
          if (hit && !room) overflow <= 1'b1;
          state <= !hit ? (last ? DONE : SCAN) : room ? COPY1 : DONE;
        end
        COPY1: state <= COPY2;
        COPY2: state <= COPY3;
        COPY3: begin
          count <= count + 1'b1;
          if (idx == '0) sprite0_hit <= 1'b1;
          if (!last) idx <= idx + 1'b1;
          state <= last ? DONE : SCAN;
        end
        DONE: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sprite_eval.sv
// tb_sprite_eval: vector table plus secondary-OAM write scoreboard for sprite_eval
module tb_sprite_eval;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;
  sprite_eval_if #(.NUM_SPRITES(64), .MAX_PER_LINE(8), .Y_W(8)) bus ();
  sprite_eval #(.NUM_SPRITES(64), .MAX_PER_LINE(8), .Y_W(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  typedef struct {
    int base; int n; int y; int sl; int tl; int cnt; int ovf; int s0; int cyc; int last;
  } vec_t;
  vec_t       vt[13];
  logic [7:0] oam[256];
  int         exp_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  always @(posedge clk) bus.oam_rdata <= oam[bus.oam_addr];
  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  // Every secondary OAM write must be the next one the model predicted, as addr*256+data
  always @(negedge clk)
    if (reset_n && bus.sec_we) begin
      if (exp_q.size() == 0) chk("sec_write_unexpected", int'({bus.sec_addr, bus.sec_wdata}), -1);
      else chk("sec_write", int'({bus.sec_addr, bus.sec_wdata}), exp_q.pop_front());
    end
  function automatic int outs();
    return int'({bus.oam_addr, bus.sec_we, bus.sec_addr, bus.sec_wdata, bus.busy, bus.done,
                 bus.count, bus.overflow, bus.sprite0_hit});
  endfunction
  task automatic fill(input int base, input int n, input int y);
    for (int k = 0; k < 64; k++) begin
      oam[4*k]   = (k >= base && k < base + n) ? 8'(y) : 8'hFF;
      oam[4*k+1] = 8'(33 + k);
      oam[4*k+2] = 8'(3 + k);
      oam[4*k+3] = 8'(64 + k);
    end
  endtask
  task automatic push_exp(input int sl, input int tl);
    int n = 0;
    int d;
    for (int a = 0; a < 32; a++) exp_q.push_back(a * 256 + 255);
    for (int k = 0; k < 64; k++) begin
      d = sl - int'(oam[4*k]);
      if (d >= 0 && d < (tl != 0 ? 16 : 8)) begin
        if (n == 8) break;
        for (int b = 0; b < 4; b++) exp_q.push_back((n * 4 + b) * 256 + int'(oam[4*k+b]));
        n++;
      end
    end
  endtask
  task automatic start_run(input int sl, input int tl);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.scanline = 8'(sl);
    bus.tall = tl[0];
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.scanline = ~bus.scanline;
    bus.tall = ~tl[0];
  endtask
  task automatic wait_write(input int addr, output int found);
    int cyc = 0;
    found = 0;
    while (found == 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      found = int'(bus.sec_we && bus.sec_addr == 5'(addr) && bus.sec_wdata != 8'hFF);
    end
  endtask
  task automatic run_vec(input vec_t v, input int id);
    int cyc = 0;
    int b1 = 0;
    fill(v.base, v.n, v.y);
    push_exp(v.sl, v.tl);
    start_run(v.sl, v.tl);
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) b1 = int'(bus.busy);
    end while (!bus.done && cyc < 400);
    chk($sformatf("v%0d_done_cycle", id), cyc, v.cyc);
    chk($sformatf("v%0d_busy_first", id), b1, 1);
    chk($sformatf("v%0d_busy_at_done", id), int'(bus.busy), 0);
    chk($sformatf("v%0d_count", id), int'(bus.count), v.cnt);
    chk($sformatf("v%0d_overflow", id), int'(bus.overflow), v.ovf);
    chk($sformatf("v%0d_sprite0", id), int'(bus.sprite0_hit), v.s0);
    chk($sformatf("v%0d_last_oam_addr", id), int'(bus.oam_addr), v.last);
    chk($sformatf("v%0d_writes_left", id), exp_q.size(), 0);
    exp_q.delete();
  endtask
  initial begin
    int nd;
    int found;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.scanline = '0;
    bus.tall = 1'b0;
    fill(0, 0, 0);
    //          base n   y   sl  tl cnt ovf s0 cyc  last
    vt[0]  = '{0,  0,  0,  10, 0, 0, 0, 0, 161, 252};
    vt[1]  = '{0,  1,  5,  10, 0, 1, 0, 1, 164, 252};
    vt[2]  = '{0,  1,  5,  13, 0, 0, 0, 0, 161, 252};
    vt[3]  = '{0,  1,  5,  13, 1, 1, 0, 1, 164, 252};
    vt[4]  = '{0,  9,  20, 22, 0, 8, 1, 1, 75,  32};
    vt[5]  = '{0,  1,  254, 2, 0, 0, 0, 0, 161, 252};
    vt[6]  = '{0,  1,  30, 30, 0, 1, 0, 1, 164, 252};
    vt[7]  = '{0,  1,  23, 30, 0, 1, 0, 1, 164, 252};
    vt[8]  = '{0,  1,  22, 30, 0, 0, 0, 0, 161, 252};
    vt[9]  = '{0,  16, 15, 30, 1, 8, 1, 1, 75,  32};
    vt[10] = '{0,  64, 0,  0,  0, 8, 1, 1, 75,  32};
    vt[11] = '{0,  8,  40, 47, 0, 8, 0, 1, 185, 252};
    vt[12] = '{63, 1,  50, 50, 0, 1, 0, 0, 164, 255};
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    foreach (vt[i]) run_vec(vt[i], i);
    // A start while busy must neither restart nor add a second done
    fill(0, 1, 5);
    push_exp(10, 0);
    start_run(10, 0);
    repeat (10) @(posedge clk);
    #1 bus.start = 1'b1;
    bus.scanline = 8'd100;
    @(posedge clk); #1 bus.start = 1'b0;
    nd = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("restart_done_pulses", nd, 1);
    chk("restart_count", int'(bus.count), 1);
    chk("restart_writes_left", exp_q.size(), 0);
    exp_q.delete();
    // Abort in COPY2 of the second sprite: its last byte is never written, results freeze
    fill(0, 2, 5);
    push_exp(10, 0);
    while (exp_q.size() > 39) void'(exp_q.pop_back());
    start_run(10, 0);
    wait_write(6, found);
    chk("abort_reach_copy2", found, 1);
    #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_count", int'(bus.count), 1);
    chk("abort_sprite0", int'(bus.sprite0_hit), 1);
    chk("abort_writes_left", exp_q.size(), 0);
    nd = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("abort_no_done", nd, 0);
    exp_q.delete();
    // Reset asserted mid-copy clears outputs at once, then a fresh run is clean
    fill(0, 1, 5);
    push_exp(10, 0);
    start_run(10, 0);
    wait_write(1, found);
    chk("reset_reach_copy1", found, 1);
    #1 reset_n = 1'b0;
    #1 chk("reset_async_outputs", outs(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    run_vec(vt[1], 99);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
